// File: rtl/fetch_scb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_scb_pkg: shared types and helpers for the fetch order scoreboard.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fetch_scb_pkg;

    localparam int STAT_W     = 32;
    localparam int MAX_DATA_W = 1024;

    typedef struct packed {
        logic mismatch;
        logic overflow;
        logic underflow;
    } scb_err_t;

    // Returns lane 'lane' of width 'lane_w', zero-extended to MAX_DATA_W.
    function automatic logic [MAX_DATA_W-1:0] lane_slice(
        input logic [MAX_DATA_W-1:0] data,
        input int unsigned           lane,
        input int unsigned           lane_w
    );
        logic [MAX_DATA_W-1:0] mask;
        mask = '1;
        if (lane_w < MAX_DATA_W) begin
            mask = ~('1 << lane_w);
        end
        return (data >> (lane * lane_w)) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_scb_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_scb_queue: WIDTH x DEPTH circular buffer with flush, any DEPTH>=1. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_scb_queue #(
    parameter int WIDTH = 93,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] push_entry_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A flush with a concurrent push restarts the buffer holding just that entry.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wr_ptr  = tail_q;
        if (flush_i) begin
            head_d  = '0;
            wr_ptr  = '0;
            tail_d  = push_i ? ptr_inc('0) : '0;
            count_d = push_i ? CNT_W'(1) : '0;
        end else begin
            if (push_i) tail_d = ptr_inc(tail_q);
            if (pop_i)  head_d = ptr_inc(head_q);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i) begin
            mem_q[wr_ptr] <= push_entry_i;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[head_q];

endmodule
`default_nettype wire

// File: rtl/fetch_order_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_order_scoreboard: in-order push/pop checker for the fetch FIFO.    |
// | Statistics counters enabled by macro FETCH_SCB_STATS_EN. Revision: 1.0   |
// +--------------------------------------------------------------------------+
module fetch_order_scoreboard
    import fetch_scb_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int LANES    = 2,
    parameter int PC_W     = 32,
    parameter int PC_CHK_W = 29,
    parameter int DEPTH    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic [PC_W-1:0]            push_pc_i,
    input  logic                       pop_i,
    input  logic [LANES-1:0]           pop_lane_mask_i,
    input  logic [DATA_W-1:0]          pop_data_i,
    input  logic [PC_W-1:0]            pop_pc_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] pending_o,
    output logic [DATA_W-1:0]          exp_data_o,
    output logic [PC_CHK_W-1:0]        exp_pc_o,
    output logic                       err_mismatch_o,
    output logic [LANES-1:0]           err_lane_o,
    output logic                       err_overflow_o,
    output logic                       err_underflow_o,
    output logic                       err_sticky_o,
    output logic [STAT_W-1:0]          push_cnt_o,
    output logic [STAT_W-1:0]          pop_cnt_o,
    output logic [STAT_W-1:0]          mismatch_cnt_o
);

    localparam int LANE_W  = DATA_W / LANES;
    localparam int ENTRY_W = DATA_W + PC_CHK_W;

    logic                  q_push, q_pop, q_full, q_empty;
    logic [ENTRY_W-1:0]    q_head;
    logic [DATA_W-1:0]     head_data, ref_data;
    logic [PC_CHK_W-1:0]   head_pc, ref_pc, push_pc_chk, pop_pc_chk;
    logic                  bypass, do_cmp, pc_fail;
    logic [LANES-1:0]      lane_fail, err_lane_d, err_lane_q;
    logic [MAX_DATA_W-1:0] pop_lane, ref_lane;
    scb_err_t              err_d, err_q;
    logic                  sticky_q;
    logic                  unused_pc;

    assign push_pc_chk = push_pc_i[PC_W-1 -: PC_CHK_W];
    assign pop_pc_chk  = pop_pc_i[PC_W-1 -: PC_CHK_W];
    assign unused_pc   = ^{push_pc_i, pop_pc_i};

    // Flush outranks everything; an empty push+pop compares against the push directly.
    assign bypass = !flush_i && push_i && pop_i && q_empty;
    assign q_push = flush_i ? push_i : (push_i && !bypass && (!q_full || pop_i));
    assign q_pop  = !flush_i && pop_i && !q_empty;
    assign do_cmp = !flush_i && pop_i && (!q_empty || push_i);

    fetch_scb_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (q_push),
        .pop_i        (q_pop),
        .flush_i      (flush_i),
        .push_entry_i ({push_data_i, push_pc_chk}),
        .count_o      (pending_o),
        .full_o       (q_full),
        .empty_o      (q_empty),
        .head_o       (q_head)
    );

    assign head_data  = q_head[ENTRY_W-1:PC_CHK_W];
    assign head_pc    = q_head[PC_CHK_W-1:0];
    assign exp_data_o = q_empty ? '0 : head_data;
    assign exp_pc_o   = q_empty ? '0 : head_pc;
    assign ref_data   = bypass ? push_data_i : head_data;
    assign ref_pc     = bypass ? push_pc_chk : head_pc;

    always_comb begin
        lane_fail = '0;
        pop_lane  = '0;
        ref_lane  = '0;
        pc_fail   = (|pop_lane_mask_i) && (pop_pc_chk != ref_pc);
        for (int k = 0; k < LANES; k++) begin
            pop_lane     = lane_slice(MAX_DATA_W'(pop_data_i), unsigned'(k), unsigned'(LANE_W));
            ref_lane     = lane_slice(MAX_DATA_W'(ref_data), unsigned'(k), unsigned'(LANE_W));
            lane_fail[k] = pop_lane_mask_i[k] && (pop_lane != ref_lane);
        end
        err_lane_d      = do_cmp ? (pc_fail ? pop_lane_mask_i : lane_fail) : '0;
        err_d.mismatch  = |err_lane_d;
        err_d.overflow  = !flush_i && push_i && q_full && !pop_i;
        err_d.underflow = !flush_i && pop_i && q_empty && !push_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q      <= '0;
            err_lane_q <= '0;
            sticky_q   <= 1'b0;
        end else begin
            err_q      <= err_d;
            err_lane_q <= err_lane_d;
            sticky_q   <= sticky_q | (|err_d);
        end
    end

    assign err_mismatch_o  = err_q.mismatch;
    assign err_overflow_o  = err_q.overflow;
    assign err_underflow_o = err_q.underflow;
    assign err_lane_o      = err_lane_q;
    assign err_sticky_o    = sticky_q;

`ifdef FETCH_SCB_STATS_EN
    logic              push_acc, pop_evt;
    logic [STAT_W-1:0] push_cnt_q, pop_cnt_q, mismatch_cnt_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + STAT_W'(1) : v;
    endfunction

    assign push_acc = push_i && !err_d.overflow;
    assign pop_evt  = pop_i && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            push_cnt_q     <= '0;
            pop_cnt_q      <= '0;
            mismatch_cnt_q <= '0;
        end else begin
            push_cnt_q     <= sat_inc(push_cnt_q, push_acc);
            pop_cnt_q      <= sat_inc(pop_cnt_q, pop_evt);
            mismatch_cnt_q <= sat_inc(mismatch_cnt_q, err_d.mismatch);
        end
    end

    assign push_cnt_o     = push_cnt_q;
    assign pop_cnt_o      = pop_cnt_q;
    assign mismatch_cnt_o = mismatch_cnt_q;
`else
    assign push_cnt_o     = '0;
    assign pop_cnt_o      = '0;
    assign mismatch_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_order_scoreboard.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_fetch_order_scoreboard: directed vector bench for the scoreboard.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_order_scoreboard;

`ifdef FETCH_SCB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, push, pop, flush;
    logic [63:0] push_data, pop_data;
    logic [31:0] push_pc, pop_pc;
    logic [1:0]  mask;
    logic [2:0]  pending;
    logic [63:0] exp_data;
    logic [28:0] exp_pc;
    logic        err_mm, err_ovf, err_unf, err_st;
    logic [1:0]  err_lane;
    logic [31:0] push_cnt, pop_cnt, mm_cnt;

    always #5 clk = ~clk;

    fetch_order_scoreboard #(
        .DATA_W(64), .LANES(2), .PC_W(32), .PC_CHK_W(29), .DEPTH(4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .push_i          (push),
        .push_data_i     (push_data),
        .push_pc_i       (push_pc),
        .pop_i           (pop),
        .pop_lane_mask_i (mask),
        .pop_data_i      (pop_data),
        .pop_pc_i        (pop_pc),
        .flush_i         (flush),
        .pending_o       (pending),
        .exp_data_o      (exp_data),
        .exp_pc_o        (exp_pc),
        .err_mismatch_o  (err_mm),
        .err_lane_o      (err_lane),
        .err_overflow_o  (err_ovf),
        .err_underflow_o (err_unf),
        .err_sticky_o    (err_st),
        .push_cnt_o      (push_cnt),
        .pop_cnt_o       (pop_cnt),
        .mismatch_cnt_o  (mm_cnt)
    );

    typedef struct {
        logic        push;
        logic [63:0] pd;
        logic [31:0] pp;
        logic        pop;
        logic [1:0]  m;
        logic [63:0] od;
        logic [31:0] op;
        logic        fl;
        logic [2:0]  pend;
        logic        mm;
        logic [1:0]  lane;
        logic        ovf;
        logic        unf;
        logic        st;
        logic [63:0] ed;
        logic [28:0] ep;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [63:0] d(input int n);
        return 64'h1111_0000_2222_0000 + 64'(n);
    endfunction
    function automatic logic [31:0] p(input int n);
        return 32'h100 + 32'(8 * n);
    endfunction
    function automatic logic [28:0] c(input int n);
        logic [31:0] t;
        t = p(n) >> 3;
        return t[28:0];
    endfunction

    function automatic vec_t v(input logic push_v, input logic [63:0] pd_v, input logic [31:0] pp_v,
                               input logic pop_v, input logic [1:0] m_v, input logic [63:0] od_v,
                               input logic [31:0] op_v, input logic fl_v, input logic [2:0] pend_v,
                               input logic mm_v, input logic [1:0] lane_v, input logic ovf_v,
                               input logic unf_v, input logic st_v, input logic [63:0] ed_v,
                               input logic [28:0] ep_v);
        vec_t r;
        r.push = push_v; r.pd = pd_v; r.pp = pp_v; r.pop = pop_v; r.m = m_v; r.od = od_v;
        r.op = op_v; r.fl = fl_v; r.pend = pend_v; r.mm = mm_v; r.lane = lane_v; r.ovf = ovf_v;
        r.unf = unf_v; r.st = st_v; r.ed = ed_v; r.ep = ep_v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic drive(input logic r, input logic pu, input logic [63:0] pd, input logic [31:0] pp,
                         input logic po, input logic [1:0] m, input logic [63:0] od,
                         input logic [31:0] op, input logic fl);
        @(negedge clk);
        rst = r; push = pu; push_data = pd; push_pc = pp;
        pop = po; mask = m; pop_data = od; pop_pc = op; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int ep, input int eo, input int em);
        chk({tag, " push_cnt"}, 64'(push_cnt), STATS ? 64'(ep) : 64'd0);
        chk({tag, " pop_cnt"},  64'(pop_cnt),  STATS ? 64'(eo) : 64'd0);
        chk({tag, " mm_cnt"},   64'(mm_cnt),   STATS ? 64'(em) : 64'd0);
    endtask

    initial begin
        logic [63:0] gb;
        logic [63:0] x1;
        gb = 64'hDEAD_BEEF_0BAD_F00D;
        x1 = 64'h1 << 32;

        vecs.push_back(v(1, d(0), p(0), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, d(0), c(0)));
        vecs.push_back(v(1, d(1), p(1), 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, d(0), c(0)));
        vecs.push_back(v(1, d(2), p(2), 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, d(0), c(0)));
        vecs.push_back(v(1, d(3), p(3), 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, d(0), c(0)));
        vecs.push_back(v(0, 0, 0, 1, 2'b11, d(0), p(0), 0, 3, 0, 0, 0, 0, 0, d(1), c(1)));
        vecs.push_back(v(0, 0, 0, 1, 2'b11, d(1), p(1), 0, 2, 0, 0, 0, 0, 0, d(2), c(2)));
        vecs.push_back(v(0, 0, 0, 1, 2'b11, d(2) ^ x1, p(2), 0, 1, 1, 2'b10, 0, 0, 1, d(3), c(3)));
        vecs.push_back(v(0, 0, 0, 1, 2'b01, d(3) ^ x1, p(3), 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 2'b11, d(0), p(0), 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(1, d(5), p(5), 1, 2'b11, d(5), p(5), 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, d(6), p(6), 1, 2'b01, d(6), p(7), 0, 0, 1, 2'b01, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, d(0), p(0), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, d(0), c(0)));
        vecs.push_back(v(1, d(1), p(1), 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, d(0), c(0)));
        vecs.push_back(v(1, d(2), p(2), 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, d(0), c(0)));
        vecs.push_back(v(1, d(3), p(3), 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 1, d(0), c(0)));
        vecs.push_back(v(1, d(4), p(4), 0, 0, 0, 0, 0, 4, 0, 0, 1, 0, 1, d(0), c(0)));
        vecs.push_back(v(1, d(4), p(4), 1, 2'b11, d(0), p(0), 0, 4, 0, 0, 0, 0, 1, d(1), c(1)));
        vecs.push_back(v(0, 0, 0, 1, 2'b11, d(1), p(1), 0, 3, 0, 0, 0, 0, 1, d(2), c(2)));
        vecs.push_back(v(0, 0, 0, 1, 2'b00, gb, 32'h0, 0, 2, 0, 0, 0, 0, 1, d(3), c(3)));
        vecs.push_back(v(0, 0, 0, 1, 2'b11, d(3), p(3), 0, 1, 0, 0, 0, 0, 1, d(4), c(4)));
        vecs.push_back(v(0, 0, 0, 1, 2'b11, d(4), p(4), 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, d(9), p(9), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, d(9), c(9)));
        vecs.push_back(v(1, d(10), p(10), 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, d(9), c(9)));
        vecs.push_back(v(1, d(11), p(11), 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, d(9), c(9)));
        vecs.push_back(v(1, d(8), 32'h2000, 1, 2'b11, gb, 32'h0, 1, 1, 0, 0, 0, 0, 1, d(8), 29'h400));
        vecs.push_back(v(0, 0, 0, 1, 2'b11, d(8), 32'h2000, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 2'b11, gb, 32'h0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 2'b00, gb, 32'h0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // Reset
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset pending", 64'(pending), 64'd0);
        chk("reset exp_data", exp_data, 64'd0);
        chk("reset exp_pc", 64'(exp_pc), 64'd0);
        chk("reset errs", 64'({err_mm, err_lane, err_ovf, err_unf, err_st}), 64'd0);
        chk_cnt("reset", 0, 0, 0);

        foreach (vecs[i]) begin
            vec_t t;
            t = vecs[i];
            drive(0, t.push, t.pd, t.pp, t.pop, t.m, t.od, t.op, t.fl);
            chk($sformatf("v%0d pending", i), 64'(pending), 64'(t.pend));
            chk($sformatf("v%0d mismatch", i), 64'(err_mm), 64'(t.mm));
            chk($sformatf("v%0d lane", i), 64'(err_lane), 64'(t.lane));
            chk($sformatf("v%0d overflow", i), 64'(err_ovf), 64'(t.ovf));
            chk($sformatf("v%0d underflow", i), 64'(err_unf), 64'(t.unf));
            chk($sformatf("v%0d sticky", i), 64'(err_st), 64'(t.st));
            chk($sformatf("v%0d exp_data", i), exp_data, t.ed);
            chk($sformatf("v%0d exp_pc", i), 64'(exp_pc), 64'(t.ep));
        end
        chk_cnt("table", 15, 14, 2);

        // Statistics scenario: 5 pushes (one overflow), 4 pops, one mismatch
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt("rst2", 0, 0, 0);
        for (int n = 0; n < 5; n++) drive(0, 1, d(n), p(n), 0, 0, 0, 0, 0);
        chk("stats overflow", 64'(err_ovf), 64'd1);
        for (int n = 0; n < 4; n++)
            drive(0, 0, 0, 0, 1, 2'b11, (n == 1) ? (d(n) ^ x1) : d(n), p(n), 0);
        chk("stats pending", 64'(pending), 64'd0);
        chk_cnt("stats", 4, 4, 1);

        // Reset mid-stream with active, erroneous inputs on the reset cycle
        drive(0, 1, d(20), p(20), 0, 0, 0, 0, 0);
        drive(0, 1, d(21), p(21), 0, 0, 0, 0, 0);
        chk("mid pending before", 64'(pending), 64'd2);
        drive(1, 1, d(22), p(22), 1, 2'b11, gb, 32'h0, 0);
        chk("mid rst pending", 64'(pending), 64'd0);
        chk("mid rst exp_data", exp_data, 64'd0);
        chk("mid rst exp_pc", 64'(exp_pc), 64'd0);
        chk("mid rst errs", 64'({err_mm, err_lane, err_ovf, err_unf, err_st}), 64'd0);
        chk_cnt("mid rst", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_order_scoreboard.md
Name:
fetch_order_scoreboard

Overview:
- Synthesizable in-order scoreboard for the fetch path. It records each entry pushed into the fetch FIFO: instruction data plus the checked upper PC bits.
- On each FIFO pop, it compares the popped data (split into LANES lanes) and PC against the oldest pending entry. Mismatch, overflow and underflow are flagged.
- Sits beside fetch_fifo in simulation and emulation builds. It also serves as a formal-friendly reference model with bounded depth.
- Adds flush (fetch redirect) support and a per-lane compare mask.

Parameters:
- DATA_W, 64, instruction data width per entry; must be divisible by LANES.
- LANES, 2, output lanes per entry; lane k = data[(k+1)*DATA_W/LANES-1 : k*DATA_W/LANES].
- PC_W, 32, full PC width.
- PC_CHK_W, 29, number of PC MSBs compared; range 1..PC_W.
- DEPTH, 4, maximum pending entries; any value >= 1, need not be a power of two.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- push_i  in  1  FIFO push accepted this cycle.
- push_data_i  in  DATA_W  pushed instruction data.
- push_pc_i  in  PC_W  pushed PC.
- pop_i  in  1  FIFO pop completed this cycle.
- pop_lane_mask_i  in  LANES  lanes to compare on this pop.
- pop_data_i  in  DATA_W  popped data, lanes concatenated with lane 0 in the LSBs.
- pop_pc_i  in  PC_W  popped PC of lane 0.
- flush_i  in  1  redirect; discard all pending entries.
- pending_o  out  $clog2(DEPTH+1)  registered pending count.
- exp_data_o  out  DATA_W  head entry data; 0 when empty.
- exp_pc_o  out  PC_CHK_W  head entry checked PC bits; 0 when empty.
- err_mismatch_o  out  1  one-cycle pulse: compare failed.
- err_lane_o  out  LANES  lanes that failed, valid with err_mismatch_o.
- err_overflow_o  out  1  one-cycle pulse: push while full without pop.
- err_underflow_o  out  1  one-cycle pulse: pop with nothing to compare against.
- err_sticky_o  out  1  OR of all errors since reset.
- push_cnt_o, pop_cnt_o, mismatch_cnt_o  out  32 each  statistics (see Optional Feature).

Behaviour:
- Reset: one clock; reset is synchronous, active-high on rst_i.
  - All outputs go to 0, pointers are cleared, pending_o = 0.
  - Reset asserted mid-operation discards all entries the next edge; inputs are ignored that cycle.
- Stored entry: {push_data_i, push_pc_i[PC_W-1 -: PC_CHK_W]}.
- Circular buffer with head/tail pointers wrapping at DEPTH-1 to 0; count held in a register.
- Compare on pop:
  - Lane k fails if pop_lane_mask_i[k] = 1 and the lane data differs from the head lane.
  - PC fails if pop_pc_i[PC_W-1 -: PC_CHK_W] differs from the head PC, checked whenever any mask bit is set.
  - If mask = 0, the entry is consumed without a compare.
  - On a PC failure, all masked lanes are flagged in err_lane_o.
- Error latency: err_* outputs are registered and pulse exactly one cycle after the offending edge. err_sticky_o sets on the same cycle as the pulse.
- Event priority per cycle:
  1. flush_i: entries are cleared and pop_i is ignored (no compare, no underflow). If push_i is also set, the push becomes the sole entry (pending = 1).
  2. Empty, push_i and pop_i together: pop compares against the incoming push (bypass) and pending stays 0.
  3. Full, push_i and pop_i together: both are legal, pending is unchanged, and the head advances before the tail write lands in the freed slot.
  4. Full and push_i only: err_overflow_o pulses, the entry is dropped, and state is unchanged.
  5. Empty, pop_i only: err_underflow_o pulses and state is unchanged.
- exp_data_o / exp_pc_o are combinational from head storage; gated to 0 when pending_o = 0.
- Pushed or popped X data is not filtered; the bench owns X checks.

Optional Feature:
- Macro FETCH_SCB_STATS_EN.
- When defined: push_cnt_o, pop_cnt_o and mismatch_cnt_o count accepted pushes (overflow drops excluded), pop_i events (including underflow, excluding those ignored under flush), and mismatches respectively.
  - All three saturate at 32'hFFFF_FFFF and are cleared by reset.
- When undefined: the ports remain and are tied to 0. No counter flops are synthesized.

Decomposition:
- Package fetch_scb_pkg:
  - STAT_W = 32.
  - Typedef of the error-vector struct {mismatch, overflow, underflow}.
  - Function lane_slice for data-lane extraction.
- Sub-module fetch_scb_queue: parametrised DATA_W+PC_CHK_W by DEPTH circular buffer.
  - Provides push/pop/flush, count, full/empty and head read.
  - Handles non-power-of-two wrap.
- Compare, priority and error logic live in the top module.

Test Plan:
- Push 4 entries (data 64'h1111_0000_2222_0000 + n, pc 32'h100 + 8n), pop 4 with matching values and mask 2'b11 -> no errors; pending_o goes 4 -> 0.
- Pop with data lane 1 corrupted (upper 32 bits XOR 1), mask 2'b11 -> err_mismatch_o pulses one cycle later with err_lane_o = 2'b10, and err_sticky_o stays high. Same pop with mask 2'b01 -> no error.
- Fill DEPTH=4, then push alone -> err_overflow_o pulses and pending stays 4. Then push+pop in one cycle -> pending stays 4 with no error, and a later pop matches the new entry last.
- Empty, pop alone -> err_underflow_o pulses. Empty, push+pop of the same values -> no error and pending = 0.
- Pending 3, then flush+push of pc 32'h2000 in one cycle -> pending = 1 and exp_pc_o = 32'h2000 >> 3. A pop in a flush cycle -> no error.
- With FETCH_SCB_STATS_EN defined, 5 pushes with 1 overflow, 4 pops and 1 mismatch -> push_cnt_o = 4, pop_cnt_o = 4, mismatch_cnt_o = 1. Assert rst_i mid-stream -> all counters and outputs 0 the next cycle.
